// File: rtl/tcdm_pkg.sv
// Shared types and constants for the TCDM bank responder.
package tcdm_pkg;

  localparam int unsigned TCDM_DATA_WIDTH = 32;
  localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;

  // wen encoding of the request payload: 1 = read, 0 = write.
  localparam logic TCDM_WEN_READ = 1'b1;

  // Packed request payload {wen, be, wdata}, MSB first.
  typedef struct packed {
    logic                       wen;
    logic [TCDM_BE_WIDTH-1:0]   be;
    logic [TCDM_DATA_WIDTH-1:0] wdata;
  } tcdm_req_payload_t;

endpackage

// File: rtl/tcdm_bank_resp_if.sv
// Network slave-port bundle between the interconnect and one bank.
interface tcdm_bank_resp_if #(
  parameter int unsigned AddWidth     = 8,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned ReqDataWidth = 1 + DataWidth / 8 + DataWidth
);
  logic                    req;
  logic                    gnt;
  logic [AddWidth-1:0]     add;
  logic [ReqDataWidth-1:0] data;
  logic [DataWidth-1:0]    rdata;
  logic                    vld;

  modport master (output req, add, data, input  gnt, rdata, vld);
  modport slave  (input  req, add, data, output gnt, rdata, vld);
endinterface

// File: rtl/tcdm_bank_stall_cnt.sv
// Contention emulation: refuses the grant on every StallPeriod-th request cycle.
module tcdm_bank_stall_cnt #(
  parameter int unsigned StallPeriod = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic stall_o
);
  localparam int unsigned CntWidth = $clog2(StallPeriod) + 1;
  localparam logic [CntWidth-1:0] LastVal =
    (StallPeriod == 0) ? '0 : CntWidth'(StallPeriod - 1);
  localparam logic Enabled = (StallPeriod != 0);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Next count: advance on every request cycle, wrapping at the period; stuck at 0 when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (Enabled && req_i) begin
      cnt_d = (cnt_q == LastVal) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign stall_o = Enabled && (cnt_q == LastVal);

endmodule

// File: rtl/tcdm_bank_resp.sv
// Single-ported word-addressed SRAM bank behind one TCDM network slave port.
module tcdm_bank_resp
  import tcdm_pkg::*;
#(
  parameter int unsigned NumWords    = 256,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddWidth    = $clog2(NumWords),
  parameter int unsigned StallPeriod = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  tcdm_bank_resp_if.slave       bus
);
  localparam int unsigned BeWidth      = DataWidth / 8;
  localparam int unsigned ReqDataWidth = 1 + BeWidth + DataWidth;
  localparam int unsigned IdxWidth     = $clog2(NumWords);

  logic                 req_i;
  logic                 gnt_o;
  logic [IdxWidth-1:0]  idx;
  logic                 wen;
  logic [BeWidth-1:0]   be;
  logic [DataWidth-1:0] wdata;
  logic                 stall;
  logic                 granted;

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] wword_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 vld_q, vld_d;

  assign req_i = bus.req;
  // Only the low index bits address the bank; upper address bits alias.
  assign idx   = bus.add[IdxWidth-1:0];
  assign wen   = bus.data[ReqDataWidth-1];
  assign be    = bus.data[DataWidth +: BeWidth];
  assign wdata = bus.data[DataWidth-1:0];

  tcdm_bank_stall_cnt #(
    .StallPeriod (StallPeriod)
  ) i_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .stall_o (stall)
  );

  assign gnt_o   = req_i & ~stall;
  assign granted = req_i & gnt_o;

  // Merge the byte-masked write data into the addressed word.
  always_comb begin
    wword_d = mem_q[idx];
    for (int unsigned b = 0; b < BeWidth; b++) begin
      if (be[b]) wword_d[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // Read response: capture old contents on a granted read, otherwise hold data and drop valid.
  always_comb begin
    rdata_d = rdata_q;
    vld_d   = 1'b0;
    if (granted && (wen == TCDM_WEN_READ)) begin
      rdata_d = mem_q[idx];
      vld_d   = 1'b1;
    end
  end

  // Storage array; reset clears every word and discards a transaction granted in that cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (granted && (wen != TCDM_WEN_READ)) begin
      mem_q[idx] <= wword_d;
    end
  end

  // Response registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt   = gnt_o;
  assign bus.rdata = rdata_q;
  assign bus.vld   = vld_q;

endmodule

// File: tb/tb_tcdm_bank_resp.sv
// Directed self-checking bench: bank A (no stall, 10-bit address), bank B (StallPeriod 3).
module tb_tcdm_bank_resp;
  import tcdm_pkg::*;

  logic clk;
  logic rst_n;

  int unsigned checks;
  int unsigned errors;

  tcdm_bank_resp_if #(.AddWidth(10), .DataWidth(32)) a_if ();
  tcdm_bank_resp_if #(.AddWidth(8),  .DataWidth(32)) b_if ();

  tcdm_bank_resp #(
    .NumWords    (256),
    .DataWidth   (32),
    .AddWidth    (10),
    .StallPeriod (0)
  ) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (a_if)
  );

  tcdm_bank_resp #(
    .NumWords    (256),
    .DataWidth   (32),
    .AddWidth    (8),
    .StallPeriod (3)
  ) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic wen, input logic [3:0] be,
                         input logic [9:0] add, input logic [31:0] wdata);
    tcdm_req_payload_t p;
    p.wen = wen; p.be = be; p.wdata = wdata;
    a_if.req  = req;
    a_if.add  = add;
    a_if.data = p;
  endtask

  task automatic drive_b(input logic req, input logic wen, input logic [3:0] be,
                         input logic [7:0] add, input logic [31:0] wdata);
    tcdm_req_payload_t p;
    p.wen = wen; p.be = be; p.wdata = wdata;
    b_if.req  = req;
    b_if.add  = add;
    b_if.data = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_a(1'b0, RD, 4'h0, 10'h000, 32'h0);
    drive_b(1'b1, RD, 4'h0, 8'h00, 32'h0);
    tick();
    tick();
    check_val("rst_rdata", a_if.rdata, 32'h0);
    check_val("rst_vld",   {31'b0, a_if.vld}, 32'h0);
    check_val("rst_gnt",   {31'b0, a_if.gnt}, 32'h0);
    check_val("rst_gnt_b", {31'b0, b_if.gnt}, 32'h1);
    rst_n = 1'b1;

    // Stall pattern on bank B: req held high for 6 cycles -> 1,1,0,1,1,0
    drive_b(1'b1, WR, 4'hF, 8'h01, 32'hAAAA5555); #1;
    check_val("stall_gnt0", {31'b0, b_if.gnt}, 32'h1);
    tick();
    drive_b(1'b1, RD, 4'h0, 8'h01, 32'h0); #1;
    check_val("stall_gnt1", {31'b0, b_if.gnt}, 32'h1);
    tick();
    check_val("stall_rd1_data", b_if.rdata, 32'hAAAA5555);
    check_val("stall_rd1_vld",  {31'b0, b_if.vld}, 32'h1);
    drive_b(1'b1, RD, 4'h0, 8'h02, 32'h0); #1;
    check_val("stall_gnt2", {31'b0, b_if.gnt}, 32'h0);
    tick();
    check_val("stall_hold_data", b_if.rdata, 32'hAAAA5555);
    check_val("stall_hold_vld",  {31'b0, b_if.vld}, 32'h0);
    drive_b(1'b1, WR, 4'hF, 8'h02, 32'h12345678); #1;
    check_val("stall_gnt3", {31'b0, b_if.gnt}, 32'h1);
    tick();
    check_val("stall_wr_vld", {31'b0, b_if.vld}, 32'h0);
    drive_b(1'b1, RD, 4'h0, 8'h02, 32'h0); #1;
    check_val("stall_gnt4", {31'b0, b_if.gnt}, 32'h1);
    tick();
    check_val("stall_rd2_data", b_if.rdata, 32'h12345678);
    check_val("stall_rd2_vld",  {31'b0, b_if.vld}, 32'h1);
    drive_b(1'b1, RD, 4'h0, 8'h01, 32'h0); #1;
    check_val("stall_gnt5", {31'b0, b_if.gnt}, 32'h0);
    tick();
    check_val("stall_end_data", b_if.rdata, 32'h12345678);
    check_val("stall_end_vld",  {31'b0, b_if.vld}, 32'h0);
    drive_b(1'b0, RD, 4'h0, 8'h00, 32'h0);

    // Write then read on bank A
    drive_a(1'b1, WR, 4'hF, 10'h005, 32'hDEADBEEF); #1;
    check_val("wr_gnt", {31'b0, a_if.gnt}, 32'h1);
    tick();
    drive_a(1'b1, RD, 4'h0, 10'h005, 32'h0); #1;
    check_val("rd_gnt",    {31'b0, a_if.gnt}, 32'h1);
    check_val("wr_no_vld", {31'b0, a_if.vld}, 32'h0);
    tick();
    check_val("rd_data", a_if.rdata, 32'hDEADBEEF);
    check_val("rd_vld",  {31'b0, a_if.vld}, 32'h1);

    // Byte-masked write
    drive_a(1'b1, WR, 4'b0101, 10'h005, 32'h11223344);
    tick();
    check_val("bm_hold_data", a_if.rdata, 32'hDEADBEEF);
    check_val("bm_wr_vld",    {31'b0, a_if.vld}, 32'h0);
    drive_a(1'b1, RD, 4'h0, 10'h005, 32'h0);
    tick();
    check_val("bm_data", a_if.rdata, 32'hDE22BE44);

    // be = 0 write leaves the word unchanged
    drive_a(1'b1, WR, 4'h0, 10'h005, 32'hFFFFFFFF);
    tick();
    drive_a(1'b1, RD, 4'h0, 10'h005, 32'h0);
    tick();
    check_val("be0_data", a_if.rdata, 32'hDE22BE44);

    // Address aliasing: upper bits ignored
    drive_a(1'b1, WR, 4'hF, 10'h305, 32'hCAFEF00D);
    tick();
    drive_a(1'b1, RD, 4'h0, 10'h005, 32'h0);
    tick();
    check_val("alias_data", a_if.rdata, 32'hCAFEF00D);
    check_val("alias_vld",  {31'b0, a_if.vld}, 32'h1);

    // Unwritten word reads zero
    drive_a(1'b1, RD, 4'h0, 10'h007, 32'h0);
    tick();
    check_val("fresh_data", a_if.rdata, 32'h0);

    // Idle cycle: data held, valid dropped
    drive_a(1'b1, RD, 4'h0, 10'h105, 32'h0);
    tick();
    drive_a(1'b0, RD, 4'h0, 10'h000, 32'h0);
    tick();
    check_val("idle_data", a_if.rdata, 32'hCAFEF00D);
    check_val("idle_vld",  {31'b0, a_if.vld}, 32'h0);

    // Reset mid-operation: read granted at edge k, reset at edge k+1
    drive_a(1'b1, RD, 4'h0, 10'h005, 32'h0);
    tick();
    check_val("pre_rst_data", a_if.rdata, 32'hCAFEF00D);
    rst_n = 1'b0;
    drive_a(1'b1, WR, 4'hF, 10'h009, 32'hFFFFFFFF);
    tick();
    check_val("mid_rst_data", a_if.rdata, 32'h0);
    check_val("mid_rst_vld",  {31'b0, a_if.vld}, 32'h0);
    rst_n = 1'b1;
    drive_a(1'b1, RD, 4'h0, 10'h005, 32'h0);
    tick();
    drive_a(1'b1, RD, 4'h0, 10'h009, 32'h0);
    check_val("post_rst_w5", a_if.rdata, 32'h0);
    check_val("post_rst_vld", {31'b0, a_if.vld}, 32'h1);
    tick();
    check_val("post_rst_w9", a_if.rdata, 32'h0);
    drive_a(1'b0, RD, 4'h0, 10'h000, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
